// File: rtl/uart_pkg.sv
// Shared UART definitions: serializer state encoding and bit-timing derivation,
// common to the transmit and receive sides.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  function automatic int cycles_per_bit(input int clk_hz, input int bit_rate);
    return clk_hz / bit_rate;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with full/empty flags and an occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           i_push,
  input  logic [WIDTH-1:0]               i_data,
  input  logic                           i_pop,
  output logic [WIDTH-1:0]               o_data,
  output logic                           o_full,
  output logic                           o_empty,
  output logic [$clog2(DEPTH+1)-1:0]     o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [LW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_full  = (r_count == LW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_level = r_count;
  assign o_data  = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      // A simultaneous push and pop leaves the count unchanged.
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !reset) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: a FIFO feeds a start/data/stop serializer that
// drives a registered, idle-high serial line.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BIT_RATE     = 9600,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                in_valid,
  input  logic [PAYLOAD_BITS-1:0]             in_data,
  output logic                                in_ready,
  output logic                                uart_txd,
  output logic                                uart_tx_busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_level
);

  localparam int CYCLES_PER_BIT = cycles_per_bit(CLK_HZ, BIT_RATE);
  localparam int CW = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
  localparam int BW = $clog2(PAYLOAD_BITS + 1);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CYCLES_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(PAYLOAD_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  uart_state_e             r_state;
  logic                    r_txd;
  logic [CW-1:0]           r_baud;
  logic [BW-1:0]           r_bit;
  logic [PAYLOAD_BITS-1:0] r_shift;

  logic                    w_full;
  logic                    w_empty;
  logic                    w_push;
  logic                    w_pop;
  logic [PAYLOAD_BITS-1:0] w_fifo_data;

  assign in_ready     = !w_full && !reset;
  assign w_push       = in_valid && in_ready;
  assign w_pop        = (r_state == IDLE) && !w_empty && !reset;
  assign uart_txd     = r_txd;
  assign uart_tx_busy = (r_state != IDLE) || !w_empty;

  uart_fifo #(
    .WIDTH (PAYLOAD_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (in_data),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (fifo_level)
  );

  // The line value is registered alongside the state, so each bit appears on
  // the same edge the serializer enters the corresponding state or bit slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_txd   <= 1'b1;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_txd  <= 1'b1;
          r_baud <= '0;
          r_bit  <= '0;
          if (!w_empty) begin
            r_state <= START;
            r_txd   <= 1'b0;
            r_shift <= w_fifo_data;
          end
        end
        START: begin
          if (r_baud == BAUD_LAST) begin
            r_baud  <= '0;
            r_state <= DATA;
            r_txd   <= r_shift[0];
            r_shift <= r_shift >> 1;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        DATA: begin
          if (r_baud == BAUD_LAST) begin
            r_baud <= '0;
            if (r_bit == DATA_LAST) begin
              r_bit   <= '0;
              r_state <= STOP;
              r_txd   <= 1'b1;
            end else begin
              r_bit   <= r_bit + 1'b1;
              r_txd   <= r_shift[0];
              r_shift <= r_shift >> 1;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        STOP: begin
          if (r_baud == BAUD_LAST) begin
            r_baud <= '0;
            if (r_bit == STOP_LAST) begin
              r_bit   <= '0;
              r_state <= IDLE;
            end else begin
              r_bit <= r_bit + 1'b1;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Scoreboard bench for uart_tx_buffered at 10 clocks per bit: accepted bytes are
// queued as expectations and compared against frames decoded from uart_txd.
module tb_uart_tx_buffered;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, uart_txd, uart_tx_busy;
  logic [4:0] fifo_level;

  logic       v2 = 1'b0;
  logic [7:0] d2 = 8'h00;
  logic       rdy2, txd2, busy2;
  logic [4:0] lvl2;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int         rx_t[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_buffered #(
    .CLK_HZ(1_000_000), .BIT_RATE(100_000), .PAYLOAD_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(16)
  ) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .uart_txd(uart_txd), .uart_tx_busy(uart_tx_busy), .fifo_level(fifo_level)
  );

  uart_tx_buffered #(
    .CLK_HZ(1_000_000), .BIT_RATE(100_000), .PAYLOAD_BITS(8), .STOP_BITS(2), .FIFO_DEPTH(16)
  ) u_dut2 (
    .clk(clk), .reset(reset), .in_valid(v2), .in_data(d2), .in_ready(rdy2),
    .uart_txd(txd2), .uart_tx_busy(busy2), .fifo_level(lvl2)
  );

  // Frame decoder: samples each bit at its centre, counted in negedges from the
  // first low sample; a reset abandons the frame in progress.
  logic       mon_active = 1'b0;
  int         mon_n = 0;
  int         mon_start = 0;
  logic [7:0] mon_sh = 8'h00;

  always @(negedge clk) begin
    if (reset) begin
      mon_active <= 1'b0;
    end else if (!mon_active) begin
      if (uart_txd === 1'b0) begin
        mon_active <= 1'b1;
        mon_n      <= 1;
        mon_start  <= cyc;
      end
    end else begin
      mon_n <= mon_n + 1;
      if (mon_n >= 15 && mon_n <= 85 && (mon_n % 10) == 5) mon_sh <= {uart_txd, mon_sh[7:1]};
      if (mon_n == 95) begin
        rx_q.push_back(mon_sh);
        rx_t.push_back(mon_start);
        mon_active <= 1'b0;
      end
    end
  end

  task automatic wait_start(input int limit, output int t, output bit ok);
    logic prev;
    ok = 1'b0;
    t  = 0;
    @(negedge clk);
    prev = uart_txd;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (prev === 1'b1 && uart_txd === 1'b0) begin
        ok = 1'b1;
        t  = cyc;
        return;
      end
      prev = uart_txd;
    end
  endtask

  task automatic wait_rx(input int n, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (rx_q.size() >= n) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int lows;
    reset = 1'b1; in_valid = 1'b1; in_data = 8'h5A;
    repeat (3) @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_in_ready: got %b want 0", in_ready); end
    total++; if (uart_txd !== 1'b1) begin bad++; $display("[TB] FAIL reset_txd: got %b want 1", uart_txd); end
    total++; if (uart_tx_busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", uart_tx_busy); end
    total++; if (fifo_level !== 5'd0) begin bad++; $display("[TB] FAIL reset_level: got %0d want 0", fifo_level); end
    in_valid = 1'b0; reset = 1'b0;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL ready_after_reset: got %b want 1", in_ready); end
    total++; if (fifo_level !== 5'd0) begin bad++; $display("[TB] FAIL level_after_reset: got %0d want 0", fifo_level); end
    lows = 0;
    repeat (20) begin @(negedge clk); if (uart_txd !== 1'b1) lows++; end
    total++; if (lows != 0) begin bad++; $display("[TB] FAIL idle_line: got %0d low samples want 0", lows); end
  endtask

  task automatic test_single();
    logic [9:0] fr;
    logic [7:0] e, r;
    int t, errs, first_j;
    bit ok;
    fr = {1'b1, 8'hA5, 1'b0};
    @(negedge clk); in_valid = 1'b1; in_data = 8'hA5;
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL single_ready: got %b want 1", in_ready); end
    exp_q.push_back(8'hA5);
    @(posedge clk); #1 in_valid = 1'b0; in_data = 8'hFF;
    wait_start(50, t, ok);
    total++;
    if (!ok) begin
      bad++; $display("[TB] FAIL single_start: no start bit within 50 clk");
    end else begin
      errs = 0; first_j = -1;
      for (int j = 0; j < 100; j++) begin
        if (j > 0) @(negedge clk);
        if (uart_txd !== fr[j/10]) begin errs++; if (first_j < 0) first_j = j; end
      end
      if (errs != 0) begin bad++; $display("[TB] FAIL single_waveform: %0d wrong samples, first at offset %0d, want 0", errs, first_j); end
      total++; if (uart_tx_busy !== 1'b1) begin bad++; $display("[TB] FAIL single_busy_99: got %b want 1", uart_tx_busy); end
      @(negedge clk);
      total++; if (uart_tx_busy !== 1'b0) begin bad++; $display("[TB] FAIL single_busy_100: got %b want 0", uart_tx_busy); end
      total++; if (uart_txd !== 1'b1) begin bad++; $display("[TB] FAIL single_idle_txd: got %b want 1", uart_txd); end
    end
    wait_rx(1, 300, ok);
    total++; if (!ok) begin bad++; $display("[TB] FAIL single_rx: got %0d frames want 1", rx_q.size()); end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      e = exp_q.pop_front(); r = rx_q.pop_front(); void'(rx_t.pop_front());
      total++; if (r !== e) begin bad++; $display("[TB] FAIL single_byte: got %h want %h", r, e); end
    end
    exp_q.delete();
  endtask

  task automatic test_fill();
    int idx, acc_before;
    logic [4:0] lvl_drop;
    bit acc, drop_seen, ok;
    logic [7:0] e, r;
    idx = 0; acc_before = -1; drop_seen = 1'b0; lvl_drop = '0;
    @(negedge clk); in_valid = 1'b1; in_data = 8'h00;
    for (int c = 0; c < 5000 && idx < 20; c++) begin
      acc = (in_ready === 1'b1);
      if (acc) exp_q.push_back(8'(idx));
      else if (!drop_seen) begin drop_seen = 1'b1; acc_before = idx; lvl_drop = fifo_level; end
      @(posedge clk);
      if (acc) idx++;
      #1 in_data = 8'(idx);
      if (idx == 20) in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    total++; if (acc_before != 17) begin bad++; $display("[TB] FAIL fill_accepted: got %0d want 17", acc_before); end
    total++; if (lvl_drop !== 5'd16) begin bad++; $display("[TB] FAIL fill_level_full: got %0d want 16", lvl_drop); end
    wait_rx(20, 2600, ok);
    total++; if (!ok) begin bad++; $display("[TB] FAIL fill_rx: got %0d frames want 20", rx_q.size()); end
    for (int i = 1; i < rx_t.size(); i++) begin
      total++;
      if (rx_t[i] - rx_t[i-1] != 101) begin bad++; $display("[TB] FAIL fill_spacing[%0d]: got %0d want 101", i, rx_t[i] - rx_t[i-1]); end
    end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      e = exp_q.pop_front(); r = rx_q.pop_front(); void'(rx_t.pop_front());
      total++; if (r !== e) begin bad++; $display("[TB] FAIL fill_byte: got %h want %h", r, e); end
    end
    exp_q.delete(); rx_q.delete(); rx_t.delete();
    repeat (20) @(negedge clk);
  endtask

  task automatic test_full_hold();
    int idx, waited;
    bit acc, ok;
    logic [7:0] e, r;
    idx = 0;
    @(negedge clk); in_valid = 1'b1;
    for (int c = 0; c < 100 && idx < 17; c++) begin
      in_data = 8'(8'h40 + idx);
      acc = (in_ready === 1'b1);
      if (acc) exp_q.push_back(in_data);
      @(posedge clk);
      if (acc) idx++;
      @(negedge clk);
    end
    in_data = 8'h3C;
    total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL full_ready: got %b want 0", in_ready); end
    total++; if (fifo_level !== 5'd16) begin bad++; $display("[TB] FAIL full_level: got %0d want 16", fifo_level); end
    waited = 0;
    while (in_ready !== 1'b1 && waited < 200) begin @(negedge clk); waited++; end
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL full_release: in_ready still %b after 200 clk, want 1", in_ready);
      in_valid = 1'b0;
    end else begin
      total++; if (fifo_level !== 5'd15) begin bad++; $display("[TB] FAIL full_level_free: got %0d want 15", fifo_level); end
      exp_q.push_back(8'h3C);
      @(posedge clk); #1 in_valid = 1'b0; in_data = 8'h00;
      @(negedge clk);
      total++; if (fifo_level !== 5'd16) begin bad++; $display("[TB] FAIL full_level_once: got %0d want 16", fifo_level); end
    end
    wait_rx(exp_q.size(), 2200, ok);
    total++; if (!ok) begin bad++; $display("[TB] FAIL full_rx: got %0d frames want %0d", rx_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      e = exp_q.pop_front(); r = rx_q.pop_front(); void'(rx_t.pop_front());
      total++; if (r !== e) begin bad++; $display("[TB] FAIL full_byte: got %h want %h", r, e); end
    end
    repeat (30) @(negedge clk);
    total++; if (rx_q.size() != 0) begin bad++; $display("[TB] FAIL full_extra: got %0d extra frames want 0", rx_q.size()); end
    exp_q.delete(); rx_q.delete(); rx_t.delete();
  endtask

  task automatic test_push_pop();
    int idx, s;
    bit acc, found, ok;
    logic [7:0] e, r;
    idx = 0; s = 0; found = 1'b0;
    @(negedge clk); in_valid = 1'b1;
    for (int c = 0; c < 50 && idx < 5; c++) begin
      if (!found && uart_txd === 1'b0) begin found = 1'b1; s = cyc; end
      in_data = 8'(8'h61 + idx);
      acc = (in_ready === 1'b1);
      if (acc) exp_q.push_back(in_data);
      @(posedge clk);
      if (acc) idx++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (uart_txd === 1'b0) begin found = 1'b1; s = cyc; end
      else @(negedge clk);
    end
    total++;
    if (!found) begin
      bad++; $display("[TB] FAIL pushpop_start: no start bit seen");
    end else begin
      for (int i = 0; i < 300 && cyc < s + 100; i++) @(negedge clk);
      total++; if (fifo_level !== 5'd4) begin bad++; $display("[TB] FAIL pushpop_level_before: got %0d want 4", fifo_level); end
      in_valid = 1'b1; in_data = 8'h66;
      if (in_ready === 1'b1) exp_q.push_back(8'h66);
      @(posedge clk); #1 in_valid = 1'b0; in_data = 8'h00;
      @(negedge clk);
      total++; if (fifo_level !== 5'd4) begin bad++; $display("[TB] FAIL pushpop_level: got %0d want 4", fifo_level); end
      total++; if (uart_txd !== 1'b0) begin bad++; $display("[TB] FAIL pushpop_next_start: got %b want 0", uart_txd); end
    end
    wait_rx(exp_q.size(), 900, ok);
    total++; if (!ok) begin bad++; $display("[TB] FAIL pushpop_rx: got %0d frames want %0d", rx_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      e = exp_q.pop_front(); r = rx_q.pop_front(); void'(rx_t.pop_front());
      total++; if (r !== e) begin bad++; $display("[TB] FAIL pushpop_byte: got %h want %h", r, e); end
    end
    exp_q.delete(); rx_q.delete(); rx_t.delete();
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int idx, s, lows;
    bit acc, found;
    logic [7:0] bytes [6];
    bytes = '{8'hFF, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    idx = 0; s = 0; found = 1'b0;
    @(negedge clk); in_valid = 1'b1;
    for (int c = 0; c < 50 && idx < 6; c++) begin
      if (!found && uart_txd === 1'b0) begin found = 1'b1; s = cyc; end
      in_data = bytes[idx];
      acc = (in_ready === 1'b1);
      @(posedge clk);
      if (acc) idx++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    total++;
    if (!found) begin
      bad++; $display("[TB] FAIL rstmid_start: no start bit seen");
    end else begin
      for (int i = 0; i < 100 && cyc < s + 44; i++) @(negedge clk);
      total++; if (fifo_level !== 5'd5) begin bad++; $display("[TB] FAIL rstmid_level_before: got %0d want 5", fifo_level); end
      reset = 1'b1;
      @(negedge clk);
      total++; if (uart_txd !== 1'b1) begin bad++; $display("[TB] FAIL rstmid_txd: got %b want 1", uart_txd); end
      total++; if (fifo_level !== 5'd0) begin bad++; $display("[TB] FAIL rstmid_level: got %0d want 0", fifo_level); end
      total++; if (uart_tx_busy !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_busy: got %b want 0", uart_tx_busy); end
      @(negedge clk);
      reset = 1'b0;
    end
    lows = 0;
    repeat (1200) begin @(negedge clk); if (uart_txd !== 1'b1) lows++; end
    total++; if (lows != 0) begin bad++; $display("[TB] FAIL rstmid_no_frame: got %0d low samples want 0", lows); end
    total++; if (rx_q.size() != 0) begin bad++; $display("[TB] FAIL rstmid_rx: got %0d frames want 0", rx_q.size()); end
    exp_q.delete(); rx_q.delete(); rx_t.delete();
  endtask

  task automatic test_stop2();
    int lo, hi, lo2, w;
    bit found;
    @(negedge clk); v2 = 1'b1; d2 = 8'h00;
    total++; if (rdy2 !== 1'b1) begin bad++; $display("[TB] FAIL stop2_ready: got %b want 1", rdy2); end
    @(posedge clk); @(posedge clk); #1 v2 = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin @(negedge clk); if (txd2 === 1'b0) found = 1'b1; end
    total++;
    if (!found) begin
      bad++; $display("[TB] FAIL stop2_start: no start bit within 50 clk");
    end else begin
      lo = 0;  while (txd2 === 1'b0 && lo < 200) begin lo++; @(negedge clk); end
      hi = 0;  while (txd2 === 1'b1 && hi < 200) begin hi++; @(negedge clk); end
      lo2 = 0; while (txd2 === 1'b0 && lo2 < 200) begin lo2++; @(negedge clk); end
      total++; if (lo != 90) begin bad++; $display("[TB] FAIL stop2_low1: got %0d want 90", lo); end
      total++; if (hi != 21) begin bad++; $display("[TB] FAIL stop2_gap: got %0d want 21", hi); end
      total++; if (lo2 != 90) begin bad++; $display("[TB] FAIL stop2_low2: got %0d want 90", lo2); end
      w = 0; while (busy2 !== 1'b0 && w < 100) begin w++; @(negedge clk); end
      total++; if (w != 20) begin bad++; $display("[TB] FAIL stop2_busy_fall: got %0d want 20", w); end
      total++; if (lvl2 !== 5'd0) begin bad++; $display("[TB] FAIL stop2_level: got %0d want 0", lvl2); end
    end
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_single();
    test_fill();
    test_full_hold();
    test_push_pop();
    test_reset_mid();
    test_stop2();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
